// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to count 0 .. n-1 (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives, the subtract-side
// twin of the full_adder cell.
module full_subtractor (
  output logic bout,
  output logic d,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic t, na, nt, p, q;

  xor g_x1 (t, a, b);
  xor g_x2 (d, t, bin);
  not g_n1 (na, a);
  and g_a1 (p, na, b);
  not g_n2 (nt, t);
  and g_a2 (q, nt, bin);
  or  g_o1 (bout, p, q);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor d = a - b - bin, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             fs_d, fs_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .bout (fs_bout),
    .d    (fs_d),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          d_d      = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        d_d      = {fs_d, d_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CW'(1);
        // Final borrow/overflow are loaded on the last shift edge so they
        // are already valid in the cycle that done is high.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bout_d  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes expected
// results, a monitor pops and checks them on every done pulse.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("busy_done_overlap", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("d", {28'd0, d}, {28'd0, e.d});
        chk("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Issue one operation and check busy/done timing; if ign_at >= 0 a stray
  // start (1 - 1) is pulsed at that shift cycle and must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input logic [W-1:0] ed,
                        input logic eb, input logic eo, input int ign_at);
    exp_t e;
    e.d = ed; e.bout = eb; e.ovf = eo;
    sb.push_back(e);
    start = 1'b1; a = ta; b = tb_; bin = tbin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    for (int i = 0; i < int'(W); i++) begin
      if (i > 0) @(negedge clk);
      if (i == ign_at) begin
        start = 1'b1; a = 4'd1; b = 4'd1; bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      chk("busy_during_shift", {31'd0, busy}, 32'd1);
      chk("no_early_done", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_latency", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
    chk("d_held", {28'd0, d}, {28'd0, ed});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", {28'd0, d}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd7, 4'd3, 1'b0, 4'b0100, 1'b0, 1'b0, -1);
    run_op(4'd3, 4'd7, 1'b0, 4'b1100, 1'b1, 1'b0, -1);

    // Abort in the second shift cycle; outputs must clear immediately.
    start = 1'b1; a = 4'd12; b = 4'd3; bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_d", {28'd0, d}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end

    run_op(4'd5, 4'd1, 1'b0, 4'd4, 1'b0, 1'b0, -1);
    run_op(4'd0, 4'd0, 1'b1, 4'b1111, 1'b1, 1'b0, -1);
    run_op(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, -1);
    run_op(4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 1);
`ifdef SERIAL_SUB_OVF_EN
    run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, -1);
    run_op(4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, -1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
